red_pitaya_guitar_noise_gate: RTL and testbench

RED_PITAYA_GUITAR_NOISE_GATE -- requirements
Module: red_pitaya_guitar_noise_gate

---
 rtl/red_pitaya_guitar_pkg.sv | 21 ++
 rtl/red_pitaya_guitar_env_follower.sv | 42 ++++
 rtl/red_pitaya_guitar_noise_gate.sv | 132 +++++++++++++
 tb/tb_red_pitaya_guitar_noise_gate.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_guitar_pkg.sv
// Shared definitions for the guitar effect chain: sample width, unity gain
// and the noise gate state encoding.
package red_pitaya_guitar_pkg;

  localparam int DW = 16;
  localparam logic [15:0] GAIN_UNITY = 16'h8000;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_CLOSING = 3'd4
  } gate_state_t;

  // A zero step would freeze the ramp, so it is promoted to the smallest move.
  function automatic logic [15:0] effStep(input logic [7:0] step);
    return (step == 8'd0) ? 16'd1 : {8'd0, step};
  endfunction

endpackage

// File: rtl/red_pitaya_guitar_env_follower.sv
// Envelope follower: saturating magnitude of each sample smoothed by a
// one-pole filter whose time constant is set by ENV_SHIFT.
module red_pitaya_guitar_env_follower #(
  parameter int DW        = red_pitaya_guitar_pkg::DW,
  parameter int ENV_SHIFT = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic signed [DW-1:0] in_sound_i,
  output logic        [DW-1:0] env_o
);

  logic [DW-1:0]        r_env;
  logic [DW-1:0]        w_abs;
  logic signed [DW:0]   w_diff;
  logic signed [DW:0]   w_delta;

  // The most negative code has no positive twin, so it is folded onto full scale.
  always_comb begin
    if (in_sound_i == {1'b1, {(DW-1){1'b0}}}) begin
      w_abs = {1'b0, {(DW-1){1'b1}}};
    end else if (in_sound_i[DW-1]) begin
      w_abs = $unsigned(-in_sound_i);
    end else begin
      w_abs = $unsigned(in_sound_i);
    end
    w_diff  = $signed({1'b0, w_abs}) - $signed({1'b0, r_env});
    w_delta = w_diff >>> ENV_SHIFT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_env <= '0;
    end else if (in_valid_i) begin
      r_env <= DW'($signed({1'b0, r_env}) + w_delta);
    end
  end

  assign env_o = r_env;

endmodule

// File: rtl/red_pitaya_guitar_noise_gate.sv
// Noise gate with hysteresis, hold time and linear gain ramps, sitting in
// front of the octaver. Two-stage output pipeline: multiply, then rescale.
module red_pitaya_guitar_noise_gate #(
  parameter int DW        = red_pitaya_guitar_pkg::DW,
  parameter int ENV_SHIFT = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] in_sound_i,
  input  logic                 in_valid_i,
  input  logic [15:0]          thresh_open_i,
  input  logic [15:0]          thresh_close_i,
  input  logic [15:0]          hold_i,
  input  logic [7:0]           ramp_step_i,
  output logic signed [DW-1:0] out_sound_o,
  output logic                 out_valid_o,
  output logic                 gate_open_o
);

  import red_pitaya_guitar_pkg::*;

  gate_state_t            r_state;
  gate_state_t            w_nextState;
  logic [15:0]            r_gain;
  logic [15:0]            w_nextGain;
  logic [15:0]            r_holdCnt;
  logic [15:0]            w_nextHold;
  logic [15:0]            w_step;
  logic [16:0]            w_gainUp;
  logic                   w_openHit;
  logic                   w_closeHit;
  logic [DW-1:0]          w_env;
  logic signed [DW+16:0]  r_product;
  logic                   r_prodValid;
  logic signed [DW-1:0]   r_outSound;
  logic                   r_outValid;

  red_pitaya_guitar_env_follower #(
    .DW        (DW),
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_sound_i (in_sound_i),
    .env_o      (w_env)
  );

  // Decisions use the envelope register, i.e. the level before this sample.
  always_comb begin
    w_nextState = r_state;
    w_nextGain  = r_gain;
    w_nextHold  = r_holdCnt;
    w_step      = effStep(ramp_step_i);
    w_gainUp    = {1'b0, r_gain} + {1'b0, w_step};
    w_openHit   = (w_env >= thresh_open_i);
    w_closeHit  = (w_env < thresh_close_i);
    case (r_state)
      ST_CLOSED: begin
        if (w_openHit) w_nextState = ST_OPENING;
      end
      ST_OPENING: begin
        if (w_closeHit) begin
          w_nextState = ST_CLOSING;
        end else if (w_gainUp >= {1'b0, GAIN_UNITY}) begin
          w_nextGain  = GAIN_UNITY;
          w_nextState = ST_OPEN;
        end else begin
          w_nextGain = w_gainUp[15:0];
        end
      end
      ST_OPEN: begin
        if (w_closeHit) begin
          w_nextState = ST_HOLD;
          w_nextHold  = hold_i;
        end
      end
      ST_HOLD: begin
        if (w_openHit) begin
          w_nextState = ST_OPEN;
        end else if (r_holdCnt == 16'd0) begin
          w_nextState = ST_CLOSING;
        end else begin
          w_nextHold = r_holdCnt - 16'd1;
        end
      end
      ST_CLOSING: begin
        if (w_openHit) begin
          w_nextState = ST_OPENING;
        end else if (r_gain <= w_step) begin
          w_nextGain  = 16'd0;
          w_nextState = ST_CLOSED;
        end else begin
          w_nextGain = r_gain - w_step;
        end
      end
      default: w_nextState = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_CLOSED;
      r_gain    <= '0;
      r_holdCnt <= '0;
    end else if (in_valid_i) begin
      r_state   <= w_nextState;
      r_gain    <= w_nextGain;
      r_holdCnt <= w_nextHold;
    end
  end

  // Gain is widened to 17 signed bits so that 0x8000 means +1.0, not -1.0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_product   <= '0;
      r_prodValid <= 1'b0;
      r_outSound  <= '0;
      r_outValid  <= 1'b0;
    end else begin
      r_prodValid <= in_valid_i;
      if (in_valid_i) r_product <= in_sound_i * $signed({1'b0, r_gain});
      r_outValid <= r_prodValid;
      if (r_prodValid) r_outSound <= DW'(r_product >>> 15);
    end
  end

  assign out_sound_o = r_outSound;
  assign out_valid_o = r_outValid;
  assign gate_open_o = (r_state == ST_OPENING) || (r_state == ST_OPEN) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_red_pitaya_guitar_noise_gate.sv
// Self-checking bench for the noise gate: a sample-level behavioural model
// compared every cycle, plus hand-computed checkpoints for each scenario.
module tb_red_pitaya_guitar_noise_gate;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic signed [15:0] in_sound_i = '0;
  logic               in_valid_i = 1'b0;
  logic [15:0]        thresh_open_i = 16'h0800;
  logic [15:0]        thresh_close_i = 16'h0400;
  logic [15:0]        hold_i = 16'd10;
  logic [7:0]         ramp_step_i = 8'h80;
  logic signed [15:0] out_sound_o;
  logic               out_valid_o;
  logic               gate_open_o;

  red_pitaya_guitar_noise_gate dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_sound_i     (in_sound_i),
    .in_valid_i     (in_valid_i),
    .thresh_open_i  (thresh_open_i),
    .thresh_close_i (thresh_close_i),
    .hold_i         (hold_i),
    .ramp_step_i    (ramp_step_i),
    .out_sound_o    (out_sound_o),
    .out_valid_o    (out_valid_o),
    .gate_open_o    (gate_open_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: the gate is described as a mode name, a gain in 1/32768 units
  // and a sample countdown; outputs travel through a two-slot delay line.
  localparam int M_SHUT = 0, M_RISE = 1, M_FULL = 2, M_WAIT = 3, M_FALL = 4;
  int mEnv = 0, mGain = 0, mHold = 0, mMode = M_SHUT;
  int p1Valid = 0, p1Data = 0, expValid = 0, expOut = 0;

  always @(posedge clk_i) begin : model
    int s, a, e, st;
    if (rst_i) begin
      mEnv = 0; mGain = 0; mHold = 0; mMode = M_SHUT;
      p1Valid = 0; p1Data = 0; expValid = 0; expOut = 0;
    end else begin
      expValid = p1Valid;
      if (p1Valid != 0) expOut = p1Data;
      p1Valid = in_valid_i ? 1 : 0;
      if (in_valid_i) begin
        s = int'(in_sound_i);
        p1Data = int'((longint'(s) * longint'(mGain)) >>> 15);
        a = (s == -32768) ? 32767 : ((s < 0) ? -s : s);
        e = mEnv;
        st = (ramp_step_i == 0) ? 1 : int'(ramp_step_i);
        case (mMode)
          M_SHUT: if (e >= int'(thresh_open_i)) mMode = M_RISE;
          M_RISE: begin
            if (e < int'(thresh_close_i)) mMode = M_FALL;
            else begin
              mGain = (mGain + st > 32768) ? 32768 : mGain + st;
              if (mGain == 32768) mMode = M_FULL;
            end
          end
          M_FULL: if (e < int'(thresh_close_i)) begin mMode = M_WAIT; mHold = int'(hold_i); end
          M_WAIT: begin
            if (e >= int'(thresh_open_i)) mMode = M_FULL;
            else if (mHold == 0) mMode = M_FALL;
            else mHold = mHold - 1;
          end
          default: begin
            if (e >= int'(thresh_open_i)) mMode = M_RISE;
            else begin
              mGain = (mGain - st < 0) ? 0 : mGain - st;
              if (mGain == 0) mMode = M_SHUT;
            end
          end
        endcase
        mEnv = e + ((a - e) >>> 6);
      end
    end
  end

  always @(negedge clk_i) begin
    if (checkEn) begin
      checkOutput("out_valid", int'(out_valid_o), expValid);
      checkOutput("out_sound", int'(out_sound_o), expOut);
      checkOutput("gate_open", int'(gate_open_o),
                  (mMode == M_RISE || mMode == M_FULL || mMode == M_WAIT) ? 1 : 0);
    end
  end

  // Statistics over valid output samples, used by the hand-computed checkpoints.
  int rampCnt, unityCnt, unityVal, maxJump, minOut, prevOut, validSeen;
  bit havePrev;

  always @(negedge clk_i) begin : monitor
    int v, d;
    if (!rst_i && out_valid_o) begin
      v = int'(out_sound_o);
      if (v > 0 && v < 32'h4000) rampCnt++;
      if (v == unityVal) unityCnt++;
      if (havePrev) begin
        d = (v > prevOut) ? v - prevOut : prevOut - v;
        if (d > maxJump) maxJump = d;
      end
      if (v < minOut) minOut = v;
      prevOut = v;
      havePrev = 1'b1;
      validSeen++;
    end
  end

  task automatic clearStats(input int uv);
    rampCnt = 0; unityCnt = 0; unityVal = uv; maxJump = 0;
    minOut = 32'h7fffffff; prevOut = 0; havePrev = 1'b0; validSeen = 0;
  endtask

  task automatic applyStimulus(input logic signed [15:0] s, input logic v);
    @(posedge clk_i);
    #1;
    in_sound_i = s;
    in_valid_i = v;
  endtask

  task automatic runSamples(input logic signed [15:0] s, input int n);
    for (int i = 0; i < n; i++) applyStimulus(s, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(16'sd0, 1'b0);
  endtask

  task automatic settle();
    idle(3);
    @(negedge clk_i);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic setCfg(input logic [15:0] op, input logic [15:0] cl, input logic [15:0] hd,
                        input logic [7:0] st);
    thresh_open_i = op; thresh_close_i = cl; hold_i = hd; ramp_step_i = st;
  endtask

  initial begin
    clearStats(0);
    @(posedge clk_i);
    checkEn = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    checkOutput("reset_out_sound", int'(out_sound_o), 0);
    checkOutput("reset_out_valid", int'(out_valid_o), 0);
    checkOutput("reset_gate_open", int'(gate_open_o), 0);

    // Silence keeps the gate shut.
    runSamples(16'sd0, 100);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'sd0, 1'b1);
      applyStimulus(16'sd0, 1'b0);
    end
    settle();
    checkOutput("silence_out", int'(out_sound_o), 0);
    checkOutput("silence_gate", int'(gate_open_o), 0);

    // Single sample: valid appears on the second edge after it is taken, for one cycle.
    applyStimulus(16'sh1234, 1'b1);
    applyStimulus(16'sd0, 1'b0);
    @(negedge clk_i);
    #1;
    checkOutput("latency_edge1", int'(out_valid_o), 0);
    @(negedge clk_i);
    #1;
    checkOutput("latency_edge2", int'(out_valid_o), 1);
    @(negedge clk_i);
    #1;
    checkOutput("latency_edge3", int'(out_valid_o), 0);

    // Opening ramp: 255 intermediate outputs between 0 and 0x4000, then passthrough.
    clearStats(32'h4000);
    runSamples(16'sh4000, 300);
    settle();
    checkOutput("open_ramp_count", rampCnt, 255);
    checkOutput("open_unity_out", int'(out_sound_o), 32'h4000);
    checkOutput("open_gate", int'(gate_open_o), 1);

    // Forced close with hold 10: 13 unity outputs, then a 255-step fall, then shut.
    setCfg(16'hFFFF, 16'hFFFF, 16'd10, 8'h80);
    clearStats(32'h4000);
    runSamples(16'sh4000, 300);
    settle();
    checkOutput("hold_unity_count", unityCnt, 13);
    checkOutput("close_ramp_count", rampCnt, 255);
    checkOutput("closed_gate", int'(gate_open_o), 0);
    checkOutput("closed_out", int'(out_sound_o), 0);

    // Reopen, then let the input decay to silence through hold and closing.
    setCfg(16'h0800, 16'h0400, 16'd10, 8'h80);
    runSamples(16'sh4000, 270);
    runSamples(16'sd0, 500);
    settle();
    checkOutput("decay_gate", int'(gate_open_o), 0);

    // Full-scale negative input passes through exactly at unity gain.
    runSamples(-16'sd32768, 320);
    settle();
    checkOutput("neg_full_scale", int'(out_sound_o), -32768);
    checkOutput("neg_gate", int'(gate_open_o), 1);

    // Closing interrupted at gain 0x4000 resumes opening without a jump.
    setCfg(16'hFFFF, 16'hFFFF, 16'd0, 8'h80);
    runSamples(16'sh4000, 2);
    settle();
    clearStats(32'h4000);
    runSamples(16'sh4000, 128);
    idle(1);
    setCfg(16'h0800, 16'h0400, 16'd10, 8'h80);
    runSamples(16'sh4000, 300);
    settle();
    checkOutput("reopen_max_jump", maxJump, 64);
    checkOutput("reopen_min_out", minOut, 32'h2000);
    checkOutput("reopen_final", int'(out_sound_o), 32'h4000);

    // Reset one cycle after a sample drops it from the pipeline.
    clearStats(0);
    applyStimulus(16'sh4000, 1'b1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    settle();
    checkOutput("rst_dropped_valid", validSeen, 0);
    checkOutput("rst_out_sound", int'(out_sound_o), 0);
    checkOutput("rst_gate_open", int'(gate_open_o), 0);

    // Zero step behaves as step 1, with gaps between samples.
    setCfg(16'h0800, 16'h0400, 16'd10, 8'h00);
    for (int i = 0; i < 80; i++) begin
      applyStimulus(16'sh4000, 1'b1);
      applyStimulus(16'sh1111, 1'b0);
    end
    settle();
    checkOutput("step0_gate", int'(gate_open_o), 1);

    doReset();
    settle();
    checkOutput("final_reset_gate", int'(gate_open_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
